// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: BHT sizing, 2-bit counter
// encoding with its reset/saturation points, and small arithmetic helpers.
package branch_resolve_unit_pkg;

  // Default number of direction counters in the branch history table.
  localparam int BHT_ENTRIES_DEFAULT = 16;

  // 2-bit direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_state_e;

  // Counters come out of reset weakly not-taken and saturate at both ends.
  localparam ctr_state_e CTR_RESET = CTR_WEAK_NT;
  localparam ctr_state_e CTR_MAX   = CTR_STRONG_T;
  localparam ctr_state_e CTR_MIN   = CTR_STRONG_NT;

  // Statistics counters stick at all-ones instead of wrapping.
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Sequential fetch step used for the not-taken fall-through address.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fields written into the BTB alongside the write strobe.
  typedef struct packed {
    logic [12:0] pc;
    logic [31:0] imm;
    logic        is_branch;
  } btb_upd_t;

  // One saturating step of a direction counter.
  function automatic ctr_state_e ctr_step(input ctr_state_e cur, input logic up);
    logic [1:0] raw;
    raw = cur;
    if (up && (cur != CTR_MAX)) begin
      raw = raw + 2'd1;
    end else if (!up && (cur != CTR_MIN)) begin
      raw = raw - 2'd1;
    end
    return ctr_state_e'(raw);
  endfunction

  // Saturating increment for the 32-bit statistics.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == STAT_MAX) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter2.sv
// One BHT entry: a 2-bit up/down saturating direction counter.
module sat_counter2
  import branch_resolve_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  output logic [1:0] count
);

  ctr_state_e count_reg;

  // Step toward taken or not-taken when this entry is selected for update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= CTR_RESET;
    end else if (en) begin
      count_reg <= ctr_step(count_reg, up);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks the EX-stage control transfer against the IF
// prediction, issues a one-cycle flush/redirect on mispredict, writes the BTB
// for taken transfers it did not know, trains the BHT and keeps statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_ENTRIES = BHT_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        EX_valid,
  input  logic        EX_Branch,
  input  logic        EX_Jump,
  input  logic [31:0] EX_pc,
  input  logic        EX_taken,
  input  logic [31:0] EX_target,
  input  logic        EX_pred_hit,
  input  logic        EX_pred_taken,
  input  logic [31:0] EX_pred_target,
  input  logic [12:0] IF_pc,
  output logic        IF_pred_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        btb_write,
  output logic [12:0] btb_pc,
  output logic [31:0] btb_pc_imm,
  output logic        btb_Branch,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Registered outputs and their next-state values.
  logic        flush_reg, flush_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic        btb_write_reg, btb_write_next;
  btb_upd_t    btb_upd_reg, btb_upd_next;
  logic [31:0] br_count_reg, br_count_next;
  logic [31:0] mispred_count_reg, mispred_count_next;

  // Resolution terms.
  logic        resolve;
  logic        actual_taken;
  logic        pred_taken;
  logic        target_mismatch;
  logic        mispredict;
  logic        btb_update;
  logic [31:0] fallthrough_pc;

  // BHT signals.
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             bht_upd_en;
  logic [1:0]       bht_count [BHT_ENTRIES];
  logic             unused_if_pc_hi;

  // An instruction in the flush cycle is wrong-path, so it never resolves.
  assign resolve         = EX_valid && (EX_Branch || EX_Jump) && !stall && !flush_reg;
  assign actual_taken    = EX_Jump || EX_taken;
  assign pred_taken      = EX_pred_hit && (EX_Jump || EX_pred_taken);
  assign target_mismatch = (EX_target != EX_pred_target);
  assign mispredict      = (actual_taken != pred_taken) ||
                           (actual_taken && pred_taken && target_mismatch);
  assign btb_update      = resolve && actual_taken && (!EX_pred_hit || target_mismatch);
  assign fallthrough_pc  = EX_pc + PC_STEP;

  // Only conditional branches train the direction counters.
  assign bht_upd_en = resolve && EX_Branch;
  assign upd_idx    = EX_pc[IDX_W-1:0];
  assign if_idx     = IF_pc[IDX_W-1:0];

  // Upper fetch-PC bits play no part in the direction lookup.
  assign unused_if_pc_hi = &{1'b0, IF_pc[12:IDX_W]};

  // One counter per BHT entry, each enabled only when its index is updated.
  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      sat_counter2 u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bht_upd_en && (upd_idx == IDX_W'(gi))),
        .up    (EX_taken),
        .count (bht_count[gi])
      );
    end
  endgenerate

  // Direction lookup reads the registered counter, so a same-cycle update
  // to the same entry is seen only from the next cycle on.
  assign IF_pred_taken = bht_count[if_idx][1];

  // Next-state: pulses are recomputed every cycle, data fields hold unless
  // a new event loads them.
  always_comb begin
    flush_next         = resolve && mispredict;
    btb_write_next     = btb_update;
    redirect_pc_next   = redirect_pc_reg;
    btb_upd_next       = btb_upd_reg;
    br_count_next      = br_count_reg;
    mispred_count_next = mispred_count_reg;

    if (resolve && mispredict) begin
      redirect_pc_next   = actual_taken ? EX_target : fallthrough_pc;
      mispred_count_next = sat_inc32(mispred_count_reg);
    end
    if (btb_update) begin
      btb_upd_next.pc        = EX_pc[12:0];
      btb_upd_next.imm       = EX_target;
      btb_upd_next.is_branch = EX_Branch;
    end
    if (resolve) begin
      br_count_next = sat_inc32(br_count_reg);
    end
  end

  // Output and statistics registers; reset also cancels any pending pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_reg         <= 1'b0;
      redirect_pc_reg   <= 32'd0;
      btb_write_reg     <= 1'b0;
      btb_upd_reg       <= '{pc: 13'd0, imm: 32'd0, is_branch: 1'b1};
      br_count_reg      <= 32'd0;
      mispred_count_reg <= 32'd0;
    end else begin
      flush_reg         <= flush_next;
      redirect_pc_reg   <= redirect_pc_next;
      btb_write_reg     <= btb_write_next;
      btb_upd_reg       <= btb_upd_next;
      br_count_reg      <= br_count_next;
      mispred_count_reg <= mispred_count_next;
    end
  end

  assign flush         = flush_reg;
  assign redirect_pc   = redirect_pc_reg;
  assign btb_write     = btb_write_reg;
  assign btb_pc        = btb_upd_reg.pc;
  assign btb_pc_imm    = btb_upd_reg.imm;
  assign btb_Branch    = btb_upd_reg.is_branch;
  assign br_count      = br_count_reg;
  assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected outputs are queued when EX
// stimulus is driven and compared one cycle later when the DUT responds.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        EX_valid, EX_Branch, EX_Jump;
  logic [31:0] EX_pc;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_pred_hit, EX_pred_taken;
  logic [31:0] EX_pred_target;
  logic [12:0] IF_pc;
  logic        IF_pred_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        btb_write;
  logic [12:0] btb_pc;
  logic [31:0] btb_pc_imm;
  logic        btb_Branch;
  logic [31:0] br_count, mispred_count;

  int    checks = 0;
  int    errors = 0;
  string cur_step = "init";

  typedef struct {
    logic        flush;
    logic [31:0] redirect;
    logic        btbw;
    logic [12:0] bpc;
    logic [31:0] bimm;
    logic        bbr;
    logic [31:0] brc;
    logic [31:0] mpc;
    logic        chk_redir;
    logic        chk_btb;
  } exp_t;

  exp_t sb_q[$];

  branch_resolve_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .EX_valid       (EX_valid),
    .EX_Branch      (EX_Branch),
    .EX_Jump        (EX_Jump),
    .EX_pc          (EX_pc),
    .EX_taken       (EX_taken),
    .EX_target      (EX_target),
    .EX_pred_hit    (EX_pred_hit),
    .EX_pred_taken  (EX_pred_taken),
    .EX_pred_target (EX_pred_target),
    .IF_pc          (IF_pc),
    .IF_pred_taken  (IF_pred_taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .btb_write      (btb_write),
    .btb_pc         (btb_pc),
    .btb_pc_imm     (btb_pc_imm),
    .btb_Branch     (btb_Branch),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", cur_step, tag, obs, exp);
    end
  endtask

  task automatic ex_set(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt, input logic ph, input logic pt,
                        input logic [31:0] ptgt);
    EX_valid = v; EX_Branch = br; EX_Jump = jp; EX_pc = pc; EX_taken = tk;
    EX_target = tgt; EX_pred_hit = ph; EX_pred_taken = pt; EX_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic expect_out(input logic f, input logic [31:0] rd, input logic bw,
                            input logic [12:0] bp, input logic [31:0] bi, input logic bb,
                            input logic [31:0] brc, input logic [31:0] mpc,
                            input logic cr, input logic cb);
    exp_t e;
    e.flush = f; e.redirect = rd; e.btbw = bw; e.bpc = bp; e.bimm = bi; e.bbr = bb;
    e.brc = brc; e.mpc = mpc; e.chk_redir = cr; e.chk_btb = cb;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare the DUT response to the oldest expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", cur_step);
    end else begin
      e = sb_q.pop_front();
      chk("flush", 32'(flush), 32'(e.flush));
      chk("btb_write", 32'(btb_write), 32'(e.btbw));
      chk("br_count", br_count, e.brc);
      chk("mispred_count", mispred_count, e.mpc);
      if (e.chk_redir) chk("redirect_pc", redirect_pc, e.redirect);
      if (e.chk_btb) begin
        chk("btb_pc", 32'(btb_pc), 32'(e.bpc));
        chk("btb_pc_imm", btb_pc_imm, e.bimm);
        chk("btb_Branch", 32'(btb_Branch), 32'(e.bbr));
      end
    end
    $display("step %s: flush=%0b redirect=0x%08h btb_write=%0b btb_pc=0x%04h br=%0d mp=%0d",
             cur_step, flush, redirect_pc, btb_write, btb_pc, br_count, mispred_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    IF_pc = 13'd0;
    ex_idle();
    repeat (2) @(posedge clk);
    #1;

    cur_step = "reset";
    chk("flush", 32'(flush), 32'd0);
    chk("btb_write", 32'(btb_write), 32'd0);
    chk("redirect_pc", redirect_pc, 32'd0);
    chk("btb_pc", 32'(btb_pc), 32'd0);
    chk("btb_pc_imm", btb_pc_imm, 32'd0);
    chk("btb_Branch", 32'(btb_Branch), 32'd1);
    chk("br_count", br_count, 32'd0);
    chk("mispred_count", mispred_count, 32'd0);
    chk("if_pred", 32'(IF_pred_taken), 32'd0);
    rst_n = 1'b1;

    // Jump with no BTB hit: redirect to target and install it.
    cur_step = "jump_nohit";
    ex_set(1, 0, 1, 32'h100, 0, 32'h200, 0, 0, 32'h0);
    expect_out(1, 32'h200, 1, 13'h100, 32'h200, 0, 1, 1, 1, 1);
    tick_check();

    cur_step = "flush_idle";
    ex_idle();
    expect_out(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick_check();

    // Correctly predicted taken branch at index 0.
    cur_step = "br_taken_hit";
    IF_pc = 13'd0;
    #1;
    chk("if_pred_pre", 32'(IF_pred_taken), 32'd0);
    ex_set(1, 1, 0, 32'h40, 1, 32'h80, 1, 1, 32'h80);
    expect_out(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    tick_check();
    chk("if_pred_post", 32'(IF_pred_taken), 32'd1);

    // Not-taken branch predicted taken: fall through to pc+4.
    cur_step = "br_nt_mispred";
    ex_set(1, 1, 0, 32'h44, 0, 32'h80, 1, 1, 32'h80);
    expect_out(1, 32'h48, 0, 0, 0, 0, 3, 2, 1, 0);
    tick_check();

    cur_step = "flush_cycle_ignored";
    ex_set(1, 1, 0, 32'h50, 1, 32'h90, 0, 0, 32'h0);
    expect_out(0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
    tick_check();

    cur_step = "stall_ignored";
    stall = 1'b1;
    ex_set(1, 0, 1, 32'h300, 0, 32'h400, 0, 0, 32'h0);
    expect_out(0, 32'h48, 0, 13'h100, 32'h200, 0, 3, 2, 1, 1);
    tick_check();
    stall = 1'b0;

    // BTB hit with the wrong target.
    cur_step = "jump_tgt_mismatch";
    ex_set(1, 0, 1, 32'h104, 0, 32'h204, 1, 0, 32'h208);
    expect_out(1, 32'h204, 1, 13'h104, 32'h204, 0, 4, 3, 1, 1);
    tick_check();

    // Pulses end even though the pipe stalls; data holds.
    cur_step = "stall_in_flush";
    stall = 1'b1;
    ex_set(1, 1, 0, 32'h60, 1, 32'h90, 0, 0, 32'h0);
    expect_out(0, 32'h204, 0, 13'h104, 32'h204, 0, 4, 3, 1, 1);
    tick_check();
    stall = 1'b0;

    // Four taken branches at index 3; lookup sees pre-update value.
    cur_step = "idx3_taken";
    IF_pc = 13'd3;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("if_pred_pre", 32'(IF_pred_taken), (i == 0) ? 32'd0 : 32'd1);
      ex_set(1, 1, 0, 32'h3, 1, 32'h500, 1, 1, 32'h500);
      expect_out(0, 0, 0, 0, 0, 0, 32'(5 + i), 3, 0, 0);
      tick_check();
    end
    chk("if_pred_post", 32'(IF_pred_taken), 32'd1);

    // Two not-taken from saturated 11: 10 then 01.
    cur_step = "idx3_not_taken";
    for (int i = 0; i < 2; i++) begin
      ex_set(1, 1, 0, 32'h3, 0, 32'h500, 1, 0, 32'h500);
      expect_out(0, 0, 0, 0, 0, 0, 32'(9 + i), 3, 0, 0);
      tick_check();
      chk("if_pred_post", 32'(IF_pred_taken), (i == 0) ? 32'd1 : 32'd0);
    end

    // Index 4 is at 00; another not-taken must stay, then taken gives 01.
    cur_step = "idx4_floor";
    IF_pc = 13'd4;
    ex_set(1, 1, 0, 32'h44, 0, 32'h500, 1, 0, 32'h500);
    expect_out(0, 0, 0, 0, 0, 0, 11, 3, 0, 0);
    tick_check();
    chk("if_pred_nt", 32'(IF_pred_taken), 32'd0);
    ex_set(1, 1, 0, 32'h44, 1, 32'h500, 1, 1, 32'h500);
    expect_out(0, 0, 0, 0, 0, 0, 12, 3, 0, 0);
    tick_check();
    chk("if_pred_t", 32'(IF_pred_taken), 32'd0);

    // Taken branch with no BTB hit installs a branch entry.
    cur_step = "br_taken_nohit";
    IF_pc = 13'd0;
    ex_set(1, 1, 0, 32'h60, 1, 32'h90, 0, 0, 32'h0);
    expect_out(1, 32'h90, 1, 13'h60, 32'h90, 1, 13, 4, 1, 1);
    tick_check();
    chk("if_pred_idx0", 32'(IF_pred_taken), 32'd1);
    ex_idle();
    expect_out(0, 0, 0, 0, 0, 0, 13, 4, 0, 0);
    tick_check();

    // Reset coincides with a mispredicting jump: no pulse, all cleared.
    cur_step = "reset_cancel";
    ex_set(1, 0, 1, 32'h700, 0, 32'h800, 0, 0, 32'h0);
    rst_n = 1'b0;
    expect_out(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tick_check();
    chk("if_pred_idx0", 32'(IF_pred_taken), 32'd0);
    rst_n = 1'b1;
    ex_idle();
    cur_step = "after_reset";
    expect_out(0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    tick_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
